// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: memory, decode and redirect signals of the fetch stage.
interface ifu_fetch_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;
  modport master (
    output mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fault, fault_pc,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err, inst_ready,
           redirect_valid, redirect_pc
  );
  modport slave (
    input  mem_req_valid, mem_req_addr, inst_valid, inst, inst_pc, fault, fault_pc,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with redirect and sticky fault.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.master ifc
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d, fault_pc_q, fault_pc_d;
  logic        fault_q, fault_d, drop_q, drop_d;
  logic        redir_wait;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      drop_q     <= drop_d;
    end
  end
  // A redirect keeps us in WAIT only when a request is (or becomes) outstanding
  // and its response has not arrived yet; that response must then be dropped.
  assign redir_wait = (state_q == REQ && ifc.mem_req_ready) ||
                      (state_q == WAIT && !ifc.mem_resp_valid);
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = ifc.mem_req_ready ? WAIT : REQ;
      WAIT: if (ifc.mem_resp_valid) begin
        if (drop_q) begin
          drop_d  = 1'b0;
          state_d = REQ;
        end else if (ifc.mem_resp_err) begin
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          state_d    = FAULT;
        end else begin
          inst_d    = ifc.mem_resp_data;
          inst_pc_d = pc_q;
          state_d   = HOLD;
        end
      end
      HOLD: if (ifc.inst_ready) begin
        pc_d    = pc_q + PC_STEP;
        state_d = REQ;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (ifc.redirect_valid) begin
      pc_d       = ifc.redirect_pc & ~32'd3;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      fault_d    = 1'b0;
      fault_pc_d = fault_pc_q;
      drop_d     = redir_wait;
      state_d    = redir_wait ? WAIT : REQ;
    end
  end
  assign ifc.mem_req_valid = state_q == REQ;
  assign ifc.mem_req_addr  = pc_q;
  assign ifc.inst_valid    = state_q == HOLD;
  assign ifc.inst          = inst_q;
  assign ifc.inst_pc       = inst_pc_q;
  assign ifc.fault         = fault_q;
  assign ifc.fault_pc      = fault_pc_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed fetch scenarios; a negedge monitor scores requests and handoffs.
module tb_ifu_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ifu_fetch_if ifc ();
  ifu_fetch dut (.clk(clk), .rst_n(rst_n), .ifc(ifc.master));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_req[$];
  logic [63:0] exp_inst[$];
  int          resp_delay = 0;
  logic [31:0] err_addr = 32'h1;
  logic        pend = 1'b0;
  logic [31:0] paddr = '0;
  int          cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0010_0093 : {a[15:0], 16'h0013};
  endfunction
  // Memory responder and scoreboard monitor share the negedge, away from the active edge.
  initial forever begin
    @(negedge clk);
    ifc.mem_resp_valid = 1'b0;
    ifc.mem_resp_err   = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        ifc.mem_resp_valid = 1'b1;
        ifc.mem_resp_data  = word(paddr);
        ifc.mem_resp_err   = paddr == err_addr;
        pend = 1'b0;
      end else cnt--;
    end
    if (ifc.mem_req_valid && ifc.mem_req_ready) begin
      pend = 1'b1; paddr = ifc.mem_req_addr; cnt = resp_delay;
      if (exp_req.size() == 0) chk("unexpected_req", ifc.mem_req_addr, 32'hxxxx_xxxx);
      else chk("req_addr", ifc.mem_req_addr, exp_req.pop_front());
    end
    if (ifc.inst_valid && ifc.inst_ready) begin
      if (exp_inst.size() == 0) chk("unexpected_inst", ifc.inst_pc, 32'hxxxx_xxxx);
      else begin
        logic [63:0] e;
        e = exp_inst.pop_front();
        chk("inst", ifc.inst, e[63:32]);
        chk("inst_pc", ifc.inst_pc, e[31:0]);
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic redirect(input logic [31:0] pc);
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = pc;
    tick();
    ifc.redirect_valid = 1'b0;
  endtask
  task automatic wait_inst();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.inst_valid) break;
    end
    if (!ifc.inst_valid) chk("inst_valid_timeout", 32'(ifc.inst_valid), 32'd1);
    tick();
  endtask
  task automatic wait_req_hs();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.mem_req_valid && ifc.mem_req_ready) break;
    end
    if (!(ifc.mem_req_valid && ifc.mem_req_ready)) chk("req_hs_timeout", 32'd0, 32'd1);
    tick();
  endtask
  task automatic handoff(input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] na);
    wait_inst();
    exp_inst.push_back({ei, ep});
    exp_req.push_back(na);
    ifc.inst_ready = 1'b1;
    tick();
    ifc.inst_ready = 1'b0;
  endtask
  task automatic chk_reset_outs();
    chk("rst_req_valid", 32'(ifc.mem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(ifc.inst_valid), 32'd0);
    chk("rst_inst", ifc.inst, 32'd0);
    chk("rst_inst_pc", ifc.inst_pc, 32'd0);
    chk("rst_fault", 32'(ifc.fault), 32'd0);
    chk("rst_fault_pc", ifc.fault_pc, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    ifc.mem_req_ready = 1'b1; ifc.inst_ready = 1'b0;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = '0;
    ifc.mem_resp_valid = 1'b0; ifc.mem_resp_data = '0; ifc.mem_resp_err = 1'b0;
    repeat (3) tick();
    chk_reset_outs();
    exp_req.push_back(32'h8000_0000);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req_early", 32'(ifc.mem_req_valid), 32'd0);
    @(negedge clk);
    chk("first_req_valid", 32'(ifc.mem_req_valid), 32'd1);
    wait_inst();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_inst", ifc.inst, 32'h0010_0093);
      chk("hold_inst_pc", ifc.inst_pc, 32'h8000_0000);
      chk("hold_no_req", 32'(ifc.mem_req_valid), 32'd0);
    end
    tick();
    handoff(32'h0010_0093, 32'h8000_0000, 32'h8000_0004);
    resp_delay = 3;
    handoff(32'h0004_0013, 32'h8000_0004, 32'h8000_0008);
    wait_req_hs();
    exp_req.push_back(32'h8000_0100);
    redirect(32'h8000_0103);
    resp_delay = 0;
    handoff(32'h0100_0013, 32'h8000_0100, 32'h8000_0104);
    wait_inst();
    err_addr = 32'h8000_0008;
    exp_req.push_back(32'h8000_0008);
    redirect(32'h8000_0008);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ifc.fault) break;
    end
    chk("fault_set", 32'(ifc.fault), 32'd1);
    chk("fault_pc", ifc.fault_pc, 32'h8000_0008);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fault_no_req", 32'(ifc.mem_req_valid), 32'd0);
      chk("fault_no_inst", 32'(ifc.inst_valid), 32'd0);
    end
    tick();
    err_addr = 32'h1;
    exp_req.push_back(32'h8000_0000);
    redirect(32'h8000_0000);
    @(negedge clk);
    chk("fault_clear", 32'(ifc.fault), 32'd0);
    chk("after_fault_req", 32'(ifc.mem_req_valid), 32'd1);
    chk("after_fault_addr", ifc.mem_req_addr, 32'h8000_0000);
    tick();
    handoff(32'h0010_0093, 32'h8000_0000, 32'h8000_0004);
    wait_inst();
    ifc.mem_req_ready = 1'b0;
    exp_req.push_back(32'hFFFF_FFFC);
    redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_req_valid", 32'(ifc.mem_req_valid), 32'd1);
      chk("stall_req_addr", ifc.mem_req_addr, 32'hFFFF_FFFC);
    end
    tick();
    resp_delay = 3;
    ifc.mem_req_ready = 1'b1;
    handoff(32'hFFFC_0013, 32'hFFFF_FFFC, 32'h0000_0000);
    wait_req_hs();
    rst_n = 1'b0;
    #1;
    chk_reset_outs();
    resp_delay = 0;
    tick();
    tick();
    exp_req.push_back(32'h8000_0000);
    rst_n = 1'b1;
    handoff(32'h0010_0093, 32'h8000_0000, 32'h8000_0004);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (exp_req.size() == 0 && exp_inst.size() == 0) break;
    end
    chk("drain_req", 32'(exp_req.size()), 32'd0);
    chk("drain_inst", 32'(exp_inst.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
